mod_n_updown_counter: RTL and testbench

// - Parametrised up/down modulo-N counter with synchronous load, cascade carry/borrow and BCD digit outputs.
// - Next-generation time-field counter for the alarm clock: seconds/minutes (N=60) and hours (N=24/12).
// - Stages chain: tc of one stage drives en of the next. BCD outputs feed the 7-segment display mux directly.

---
 rtl/mod_n_updown_counter.sv | 115 +++++++++++
 tb/tb_mod_n_updown_counter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_updown_counter.sv
// Up/down modulo-N counter with synchronous load, cascade carry/borrow (tc)
// and BCD digit outputs kept in step with the binary count.
module mod_n_updown_counter #(
  parameter int W    = 6,
  parameter int N    = 60,
  parameter int WRAP = 1,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_down,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic [3:0]   tens,
  output logic [3:0]   ones,
  output logic         tc,
  output logic         wrapped
);

  localparam logic [W:0]   L_N      = (W+1)'(N);
  localparam logic [W-1:0] L_MAX    = W'(N - 1);
  localparam logic [W-1:0] L_INIT   = W'(INIT);
  localparam logic [3:0]   L_MAX_T  = 4'((N - 1) / 10);
  localparam logic [3:0]   L_MAX_O  = 4'((N - 1) % 10);
  localparam logic [3:0]   L_INIT_T = 4'(INIT / 10);
  localparam logic [3:0]   L_INIT_O = 4'(INIT % 10);

  logic [W-1:0] r_count;
  logic [3:0]   r_tens;
  logic [3:0]   r_ones;
  logic         r_wrapped;

  logic         w_at_max;
  logic         w_at_zero;
  logic         w_at_term;
  logic [W-1:0] w_ld_clamped;
  logic [7:0]   w_ld_bcd;

  // Double-dabble; inputs are always < 100 so the tens digit never overflows.
  function automatic logic [7:0] bin2bcd(input logic [6:0] b);
    logic [7:0] d;
    d = '0;
    for (int i = 6; i >= 0; i--) begin
      if (d[3:0] >= 4'd5) d[3:0] = d[3:0] + 4'd3;
      if (d[7:4] >= 4'd5) d[7:4] = d[7:4] + 4'd3;
      d = {d[6:0], b[i]};
    end
    return d;
  endfunction

  // Widened by one bit so N-1 == 2^W-1 compares without overflow.
  assign w_at_max     = ({1'b0, r_count} + (W+1)'(1)) == L_N;
  assign w_at_zero    = (r_count == '0);
  assign w_at_term    = up_down ? w_at_max : w_at_zero;
  assign w_ld_clamped = ({1'b0, load_val} >= L_N) ? L_MAX : load_val;
  assign w_ld_bcd     = bin2bcd(7'(w_ld_clamped));

  assign tc      = en & w_at_term & ~load & ~reset;
  assign count   = r_count;
  assign tens    = r_tens;
  assign ones    = r_ones;
  assign wrapped = r_wrapped;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= L_INIT;
      r_tens    <= L_INIT_T;
      r_ones    <= L_INIT_O;
      r_wrapped <= 1'b0;
    end else if (load) begin
      r_count   <= w_ld_clamped;
      r_tens    <= w_ld_bcd[7:4];
      r_ones    <= w_ld_bcd[3:0];
      r_wrapped <= 1'b0;
    end else if (en) begin
      r_wrapped <= 1'b0;
      if (w_at_term) begin
        // Saturating stages simply hold here; tc still reports the limit.
        if (WRAP != 0) begin
          r_wrapped <= 1'b1;
          if (up_down) begin
            r_count <= '0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
          end else begin
            r_count <= L_MAX;
            r_tens  <= L_MAX_T;
            r_ones  <= L_MAX_O;
          end
        end
      end else if (up_down) begin
        r_count <= r_count + W'(1);
        if (r_ones == 4'd9) begin
          r_ones <= 4'd0;
          r_tens <= r_tens + 4'd1;
        end else begin
          r_ones <= r_ones + 4'd1;
        end
      end else begin
        r_count <= r_count - W'(1);
        if (r_ones == 4'd0) begin
          r_ones <= 4'd9;
          r_tens <= r_tens - 4'd1;
        end else begin
          r_ones <= r_ones - 4'd1;
        end
      end
    end else begin
      r_wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Five counter instances (lo/hi cascade, N=24, saturating N=12, full-range N=16)
// checked against an arithmetic reference model of the counting rules.
module tb_mod_n_updown_counter;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i [NI];
  logic       up_i [NI];
  logic       ld_i [NI];
  logic [7:0] lv_i [NI];

  logic [31:0] cnt_o  [NI];
  logic [3:0]  tens_o [NI];
  logic [3:0]  ones_o [NI];
  logic        tc_o   [NI];
  logic        wr_o   [NI];

  int m_cnt [NI];
  bit m_wr  [NI];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic [5:0] a_count, b_count;
  logic [4:0] c_count;
  logic [3:0] d_count, e_count;

  // A is the low stage, B the high stage fed by A's tc.
  mod_n_updown_counter #(.W(6), .N(60), .WRAP(1), .INIT(7)) u_a (
    .clk(clk), .reset(rst), .en(en_i[0]), .up_down(up_i[0]), .load(ld_i[0]),
    .load_val(lv_i[0][5:0]), .count(a_count), .tens(tens_o[0]), .ones(ones_o[0]),
    .tc(tc_o[0]), .wrapped(wr_o[0]));
  mod_n_updown_counter #(.W(6), .N(60), .WRAP(1), .INIT(0)) u_b (
    .clk(clk), .reset(rst), .en(tc_o[0]), .up_down(up_i[1]), .load(ld_i[1]),
    .load_val(lv_i[1][5:0]), .count(b_count), .tens(tens_o[1]), .ones(ones_o[1]),
    .tc(tc_o[1]), .wrapped(wr_o[1]));
  mod_n_updown_counter #(.W(5), .N(24), .WRAP(1), .INIT(0)) u_c (
    .clk(clk), .reset(rst), .en(en_i[2]), .up_down(up_i[2]), .load(ld_i[2]),
    .load_val(lv_i[2][4:0]), .count(c_count), .tens(tens_o[2]), .ones(ones_o[2]),
    .tc(tc_o[2]), .wrapped(wr_o[2]));
  mod_n_updown_counter #(.W(4), .N(12), .WRAP(0), .INIT(0)) u_d (
    .clk(clk), .reset(rst), .en(en_i[3]), .up_down(up_i[3]), .load(ld_i[3]),
    .load_val(lv_i[3][3:0]), .count(d_count), .tens(tens_o[3]), .ones(ones_o[3]),
    .tc(tc_o[3]), .wrapped(wr_o[3]));
  mod_n_updown_counter #(.W(4), .N(16), .WRAP(1), .INIT(15)) u_e (
    .clk(clk), .reset(rst), .en(en_i[4]), .up_down(up_i[4]), .load(ld_i[4]),
    .load_val(lv_i[4][3:0]), .count(e_count), .tens(tens_o[4]), .ones(ones_o[4]),
    .tc(tc_o[4]), .wrapped(wr_o[4]));

  assign cnt_o[0] = 32'(a_count);
  assign cnt_o[1] = 32'(b_count);
  assign cnt_o[2] = 32'(c_count);
  assign cnt_o[3] = 32'(d_count);
  assign cnt_o[4] = 32'(e_count);

  function automatic int pn(int k);
    case (k) 0, 1: return 60; 2: return 24; 3: return 12; default: return 16; endcase
  endfunction
  function automatic int pw(int k);
    case (k) 0, 1: return 6; 2: return 5; default: return 4; endcase
  endfunction
  function automatic bit pwrap(int k);
    return k != 3;
  endfunction
  function automatic int pinit(int k);
    case (k) 0: return 7; 4: return 15; default: return 0; endcase
  endfunction

  function automatic bit term(int k);
    return up_i[k] ? (m_cnt[k] == pn(k) - 1) : (m_cnt[k] == 0);
  endfunction
  function automatic bit eff_en(int k);
    if (k == 1) return en_i[0] && term(0) && !ld_i[0] && !rst;
    return en_i[k];
  endfunction
  function automatic bit exp_tc(int k);
    return eff_en(k) && term(k) && !ld_i[k] && !rst;
  endfunction

  // Advance the reference model across one rising edge (no comparisons here).
  task automatic clk_edge();
    int nxt [NI];
    bit nwr [NI];
    for (int k = 0; k < NI; k++) begin
      nxt[k] = m_cnt[k];
      nwr[k] = 1'b0;
      if (rst) nxt[k] = pinit(k);
      else if (ld_i[k]) nxt[k] = (int'(lv_i[k]) >= pn(k)) ? pn(k) - 1 : int'(lv_i[k]);
      else if (eff_en(k)) begin
        if (!term(k)) nxt[k] = up_i[k] ? m_cnt[k] + 1 : m_cnt[k] - 1;
        else if (pwrap(k)) begin
          nwr[k] = 1'b1;
          nxt[k] = up_i[k] ? 0 : pn(k) - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = nxt[k];
      m_wr[k]  = nwr[k];
    end
  endtask

  task automatic idle();
    for (int k = 0; k < NI; k++) begin
      ld_i[k] = 1'b0;
      en_i[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      ld_i[k] = 1'b1; en_i[k] = 1'b1; up_i[k] = 1'b1;
      lv_i[k] = 8'($urandom_range(0, 15));
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (tc_o[k] !== 1'b0) begin n_bad++; $display("FAIL reset_tc[%0d] got=%b exp=0", k, tc_o[k]); end
    end
    clk_edge();
    for (int k = 0; k < NI; k++) begin
      n_cmp += 4;
      if (cnt_o[k] !== 32'(pinit(k))) begin n_bad++; $display("FAIL reset_count[%0d] got=%0d exp=%0d", k, cnt_o[k], pinit(k)); end
      if (tens_o[k] !== 4'(pinit(k) / 10)) begin n_bad++; $display("FAIL reset_tens[%0d] got=%0d exp=%0d", k, tens_o[k], pinit(k) / 10); end
      if (ones_o[k] !== 4'(pinit(k) % 10)) begin n_bad++; $display("FAIL reset_ones[%0d] got=%0d exp=%0d", k, ones_o[k], pinit(k) % 10); end
      if (wr_o[k] !== 1'b0) begin n_bad++; $display("FAIL reset_wrapped[%0d] got=%b exp=0", k, wr_o[k]); end
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic run_seq(string name, int k, int start, bit up, int exp_c[3], bit exp_tcv[3], bit exp_w[3]);
    idle();
    ld_i[k] = 1'b1; lv_i[k] = 8'(start);
    clk_edge();
    ld_i[k] = 1'b0;
    n_cmp++;
    if (cnt_o[k] !== 32'(start)) begin n_bad++; $display("FAIL %s_load got=%0d exp=%0d", name, cnt_o[k], start); end
    en_i[k] = 1'b1; up_i[k] = up;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (tc_o[k] !== exp_tcv[i]) begin n_bad++; $display("FAIL %s_tc[%0d] got=%b exp=%b", name, i, tc_o[k], exp_tcv[i]); end
      clk_edge();
      n_cmp += 4;
      if (cnt_o[k] !== 32'(exp_c[i])) begin n_bad++; $display("FAIL %s_count[%0d] got=%0d exp=%0d", name, i, cnt_o[k], exp_c[i]); end
      if (wr_o[k] !== exp_w[i]) begin n_bad++; $display("FAIL %s_wrapped[%0d] got=%b exp=%b", name, i, wr_o[k], exp_w[i]); end
      if (tens_o[k] !== 4'(exp_c[i] / 10)) begin n_bad++; $display("FAIL %s_tens[%0d] got=%0d exp=%0d", name, i, tens_o[k], exp_c[i] / 10); end
      if (ones_o[k] !== 4'(exp_c[i] % 10)) begin n_bad++; $display("FAIL %s_ones[%0d] got=%0d exp=%0d", name, i, ones_o[k], exp_c[i] % 10); end
    end
    idle();
  endtask

  task automatic test_wrap_up();
    run_seq("wrap_up", 0, 58, 1'b1, '{59, 0, 1}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0});
  endtask

  task automatic test_wrap_down();
    run_seq("wrap_down", 0, 1, 1'b0, '{0, 59, 58}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0});
  endtask

  task automatic test_load_clamp();
    int lv;
    int exp;
    idle();
    ld_i[2] = 1'b1; lv_i[2] = 8'd30;
    clk_edge();
    n_cmp += 3;
    if (cnt_o[2] !== 32'd23) begin n_bad++; $display("FAIL clamp_count got=%0d exp=23", cnt_o[2]); end
    if (tens_o[2] !== 4'd2) begin n_bad++; $display("FAIL clamp_tens got=%0d exp=2", tens_o[2]); end
    if (ones_o[2] !== 4'd3) begin n_bad++; $display("FAIL clamp_ones got=%0d exp=3", ones_o[2]); end
    lv_i[2] = 8'd9; en_i[2] = 1'b1; up_i[2] = 1'b1;
    #1;
    n_cmp++;
    if (tc_o[2] !== 1'b0) begin n_bad++; $display("FAIL load_over_en_tc got=%b exp=0", tc_o[2]); end
    clk_edge();
    n_cmp++;
    if (cnt_o[2] !== 32'd9) begin n_bad++; $display("FAIL load_over_en_count got=%0d exp=9", cnt_o[2]); end
    for (int i = 0; i < 8; i++) begin
      lv = $urandom_range(0, 31);
      exp = (lv >= 24) ? 23 : lv;
      lv_i[2] = 8'(lv); en_i[2] = 1'($urandom_range(0, 1)); up_i[2] = 1'($urandom_range(0, 1));
      clk_edge();
      n_cmp += 3;
      if (cnt_o[2] !== 32'(exp)) begin n_bad++; $display("FAIL rload_count lv=%0d got=%0d exp=%0d", lv, cnt_o[2], exp); end
      if (tens_o[2] !== 4'(exp / 10)) begin n_bad++; $display("FAIL rload_tens lv=%0d got=%0d exp=%0d", lv, tens_o[2], exp / 10); end
      if (ones_o[2] !== 4'(exp % 10)) begin n_bad++; $display("FAIL rload_ones lv=%0d got=%0d exp=%0d", lv, ones_o[2], exp % 10); end
    end
    idle();
  endtask

  task automatic test_saturate();
    idle();
    ld_i[3] = 1'b1; lv_i[3] = 8'd10;
    clk_edge();
    ld_i[3] = 1'b0; en_i[3] = 1'b1; up_i[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (tc_o[3] !== (i > 0)) begin n_bad++; $display("FAIL sat_up_tc[%0d] got=%b exp=%b", i, tc_o[3], i > 0); end
      clk_edge();
      n_cmp += 2;
      if (cnt_o[3] !== 32'd11) begin n_bad++; $display("FAIL sat_up_count[%0d] got=%0d exp=11", i, cnt_o[3]); end
      if (wr_o[3] !== 1'b0) begin n_bad++; $display("FAIL sat_up_wrapped[%0d] got=%b exp=0", i, wr_o[3]); end
    end
    ld_i[3] = 1'b1; lv_i[3] = 8'd0;
    clk_edge();
    ld_i[3] = 1'b0; up_i[3] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (tc_o[3] !== 1'b1) begin n_bad++; $display("FAIL sat_dn_tc[%0d] got=%b exp=1", i, tc_o[3]); end
      clk_edge();
      n_cmp += 2;
      if (cnt_o[3] !== 32'd0) begin n_bad++; $display("FAIL sat_dn_count[%0d] got=%0d exp=0", i, cnt_o[3]); end
      if (wr_o[3] !== 1'b0) begin n_bad++; $display("FAIL sat_dn_wrapped[%0d] got=%b exp=0", i, wr_o[3]); end
    end
    idle();
  endtask

  task automatic test_reset_priority();
    idle();
    ld_i[0] = 1'b1; lv_i[0] = 8'd42;
    clk_edge();
    n_cmp++;
    if (cnt_o[0] !== 32'd42) begin n_bad++; $display("FAIL rprio_load got=%0d exp=42", cnt_o[0]); end
    rst = 1'b1; lv_i[0] = 8'd20; en_i[0] = 1'b1; up_i[0] = 1'b1;
    clk_edge();
    rst = 1'b0;
    n_cmp += 4;
    if (cnt_o[0] !== 32'd7) begin n_bad++; $display("FAIL rprio_count got=%0d exp=7", cnt_o[0]); end
    if (tens_o[0] !== 4'd0) begin n_bad++; $display("FAIL rprio_tens got=%0d exp=0", tens_o[0]); end
    if (ones_o[0] !== 4'd7) begin n_bad++; $display("FAIL rprio_ones got=%0d exp=7", ones_o[0]); end
    if (wr_o[0] !== 1'b0) begin n_bad++; $display("FAIL rprio_wrapped got=%b exp=0", wr_o[0]); end
    idle();
  endtask

  task automatic test_cascade();
    int lo_wraps = 0;
    int hi_wraps = 0;
    idle();
    ld_i[0] = 1'b1; ld_i[1] = 1'b1; lv_i[0] = 8'd0; lv_i[1] = 8'd0;
    up_i[0] = 1'b1; up_i[1] = 1'b1;
    clk_edge();
    ld_i[0] = 1'b0; ld_i[1] = 1'b0; en_i[0] = 1'b1;
    for (int i = 0; i < 3600; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (tc_o[k] !== exp_tc(k)) begin n_bad++; $display("FAIL casc_tc[%0d] cyc=%0d got=%b exp=%b", k, i, tc_o[k], exp_tc(k)); end
      end
      clk_edge();
      if (wr_o[0] === 1'b1) lo_wraps++;
      if (wr_o[1] === 1'b1) hi_wraps++;
      for (int k = 0; k < 2; k++) begin
        n_cmp += 3;
        if (cnt_o[k] !== 32'(m_cnt[k])) begin n_bad++; $display("FAIL casc_count[%0d] cyc=%0d got=%0d exp=%0d", k, i, cnt_o[k], m_cnt[k]); end
        if ((32'(tens_o[k]) * 10 + 32'(ones_o[k])) !== cnt_o[k] || ones_o[k] > 4'd9) begin
          n_bad++; $display("FAIL casc_bcd[%0d] cyc=%0d tens=%0d ones=%0d count=%0d", k, i, tens_o[k], ones_o[k], cnt_o[k]);
        end
        if (wr_o[k] !== m_wr[k]) begin n_bad++; $display("FAIL casc_wrapped[%0d] cyc=%0d got=%b exp=%b", k, i, wr_o[k], m_wr[k]); end
      end
    end
    n_cmp += 4;
    if (cnt_o[0] !== 32'd0) begin n_bad++; $display("FAIL casc_lo_final got=%0d exp=0", cnt_o[0]); end
    if (cnt_o[1] !== 32'd0) begin n_bad++; $display("FAIL casc_hi_final got=%0d exp=0", cnt_o[1]); end
    if (hi_wraps != 1) begin n_bad++; $display("FAIL casc_hi_wraps got=%0d exp=1", hi_wraps); end
    if (lo_wraps != 60) begin n_bad++; $display("FAIL casc_lo_wraps got=%0d exp=60", lo_wraps); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < NI; k++) begin
        ld_i[k] = ($urandom_range(0, 7) == 0);
        lv_i[k] = 8'($urandom_range(0, (1 << pw(k)) - 1));
        en_i[k] = ($urandom_range(0, 3) != 0);
        up_i[k] = 1'($urandom_range(0, 1));
      end
      #1;
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (tc_o[k] !== exp_tc(k)) begin n_bad++; $display("FAIL rand_tc[%0d] cyc=%0d got=%b exp=%b", k, i, tc_o[k], exp_tc(k)); end
      end
      clk_edge();
      for (int k = 0; k < NI; k++) begin
        n_cmp += 4;
        if (cnt_o[k] !== 32'(m_cnt[k])) begin n_bad++; $display("FAIL rand_count[%0d] cyc=%0d got=%0d exp=%0d", k, i, cnt_o[k], m_cnt[k]); end
        if (tens_o[k] !== 4'(m_cnt[k] / 10)) begin n_bad++; $display("FAIL rand_tens[%0d] cyc=%0d got=%0d exp=%0d", k, i, tens_o[k], m_cnt[k] / 10); end
        if (ones_o[k] !== 4'(m_cnt[k] % 10)) begin n_bad++; $display("FAIL rand_ones[%0d] cyc=%0d got=%0d exp=%0d", k, i, ones_o[k], m_cnt[k] % 10); end
        if (wr_o[k] !== m_wr[k]) begin n_bad++; $display("FAIL rand_wrapped[%0d] cyc=%0d got=%b exp=%b", k, i, wr_o[k], m_wr[k]); end
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      en_i[k] = 1'b0; up_i[k] = 1'b1; ld_i[k] = 1'b0; lv_i[k] = 8'd0;
      m_cnt[k] = 0; m_wr[k] = 1'b0;
    end
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load_clamp();
    test_saturate();
    test_reset_priority();
    test_cascade();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
